// File: rtl/prbs16_checker.sv
// rtl/prbs16_checker.sv - serial PRBS16 (x^16+x^14+x^13+x^11+1) checker with lock FSM and error counters
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   data_in     received serial bit
//   data_valid  qualifies data_in; nothing advances while low
//   clear_cnt   synchronous clear of err_count/bit_count (wins over increments)
//   locked      high while the FSM sits in LOCKED
//   err_pulse   one-cycle strobe after a mismatched valid bit while LOCKED
//   err_count   saturating count of mismatches seen while LOCKED
//   bit_count   saturating count of valid bits checked while LOCKED
//   sync_state  0=ACQUIRE, 1=VERIFY, 2=LOCKED
module prbs16_checker #(
    parameter int LOCK_CNT    = 32,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic [1:0]       sync_state
);

    localparam int MW  = $clog2(LOCK_CNT + 1);
    localparam int WBW = $clog2(WIN_LEN + 1);
    localparam int EW  = $clog2(LOSS_THRESH + 1);

    localparam logic [MW-1:0]  MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WBW-1:0] WIN_LAST   = WBW'(WIN_LEN - 1);
    localparam logic [EW-1:0]  ERR_LAST   = EW'(LOSS_THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        VERIFY  = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      rx_sr, rx_sr_nxt;
    logic [4:0]       fill, fill_nxt;
    logic [MW-1:0]    match, match_nxt;
    logic [WBW-1:0]   win_bits, win_bits_nxt;
    logic [EW-1:0]    win_err, win_err_nxt;
    logic [CNT_W-1:0] err_count_nxt, bit_count_nxt;
    logic             err_pulse_nxt;

    logic        pred;
    logic        mismatch;
    logic [15:0] sr_shift;

    assign pred     = rx_sr[15] ^ rx_sr[13] ^ rx_sr[12] ^ rx_sr[10];
    assign mismatch = data_in != pred;
    assign sr_shift = {rx_sr[14:0], data_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ACQUIRE;
            rx_sr     <= '0;
            fill      <= '0;
            match     <= '0;
            win_bits  <= '0;
            win_err   <= '0;
            err_count <= '0;
            bit_count <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_sr     <= rx_sr_nxt;
            fill      <= fill_nxt;
            match     <= match_nxt;
            win_bits  <= win_bits_nxt;
            win_err   <= win_err_nxt;
            err_count <= err_count_nxt;
            bit_count <= bit_count_nxt;
            err_pulse <= err_pulse_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rx_sr_nxt     = rx_sr;
        fill_nxt      = fill;
        match_nxt     = match;
        win_bits_nxt  = win_bits;
        win_err_nxt   = win_err;
        err_count_nxt = err_count;
        bit_count_nxt = bit_count;
        err_pulse_nxt = 1'b0;

        if (data_valid) begin
            unique case (state)
                ACQUIRE: begin
                    rx_sr_nxt = sr_shift;
                    if (fill == 5'd15) begin
                        // An all-zero seed is the PRBS lock-up state; refill instead.
                        fill_nxt = '0;
                        if (sr_shift != 16'h0000) begin
                            state_nxt = VERIFY;
                        end
                    end else begin
                        fill_nxt = fill + 5'd1;
                    end
                end
                VERIFY: begin
                    rx_sr_nxt = sr_shift;
                    if (mismatch) begin
                        state_nxt = ACQUIRE;
                        fill_nxt  = '0;
                        match_nxt = '0;
                    end else if (match == MATCH_LAST) begin
                        state_nxt = LOCKED;
                        match_nxt = '0;
                    end else begin
                        match_nxt = match + MW'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: the local generator runs on its own prediction so a
                    // single corrupted bit cannot poison later predictions.
                    rx_sr_nxt = {rx_sr[14:0], pred};
                    if (bit_count != CNT_MAX) begin
                        bit_count_nxt = bit_count + CNT_W'(1);
                    end
                    if (mismatch) begin
                        err_pulse_nxt = 1'b1;
                        if (err_count != CNT_MAX) begin
                            err_count_nxt = err_count + CNT_W'(1);
                        end
                    end
                    if (mismatch && win_err == ERR_LAST) begin
                        state_nxt    = ACQUIRE;
                        fill_nxt     = '0;
                        match_nxt    = '0;
                        win_bits_nxt = '0;
                        win_err_nxt  = '0;
                    end else if (win_bits == WIN_LAST) begin
                        win_bits_nxt = '0;
                        win_err_nxt  = '0;
                    end else begin
                        win_bits_nxt = win_bits + WBW'(1);
                        if (mismatch) begin
                            win_err_nxt = win_err + EW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ACQUIRE;
                    fill_nxt  = '0;
                    match_nxt = '0;
                end
            endcase
        end

        if (clear_cnt) begin
            err_count_nxt = '0;
            bit_count_nxt = '0;
        end
    end

    assign locked     = (state == LOCKED);
    assign sync_state = state;

endmodule

// File: tb/tb_prbs16_checker.sv
// tb/tb_prbs16_checker.sv - directed self-checking bench for prbs16_checker
module tb_prbs16_checker;

    logic        clk;
    logic        reset_n;
    logic        data_in;
    logic        data_valid;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] bit_count;
    logic [1:0]  sync_state;

    prbs16_checker #(
        .LOCK_CNT(32), .WIN_LEN(64), .LOSS_THRESH(8), .CNT_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .bit_count(bit_count), .sync_state(sync_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int nbits = 0;
    logic [15:0] g;

    typedef struct {
        int         n;
        logic [1:0] st;
        logic       lk;
        int         bc;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step_raw(input logic d, input logic clr);
        @(negedge clk);
        data_in    = d;
        data_valid = 1'b1;
        clear_cnt  = clr;
        @(posedge clk);
        #1;
        if (err_pulse) pulse_cnt++;
        data_valid = 1'b0;
        clear_cnt  = 1'b0;
    endtask

    task automatic step(input logic flip, input logic clr);
        logic b;
        b = g[15] ^ g[13] ^ g[12] ^ g[10];
        g = {g[14:0], b};
        nbits++;
        step_raw(b ^ flip, clr);
    endtask

    task automatic idle();
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (err_pulse) pulse_cnt++;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        data_valid = 1'b0;
        clear_cnt  = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        g         = 16'h1001;
        nbits     = 0;
        pulse_cnt = 0;
    endtask

    initial begin
        logic left;

        tbl[0] = '{n: 15,  st: 2'd0, lk: 1'b0, bc: 0};
        tbl[1] = '{n: 16,  st: 2'd1, lk: 1'b0, bc: 0};
        tbl[2] = '{n: 47,  st: 2'd1, lk: 1'b0, bc: 0};
        tbl[3] = '{n: 48,  st: 2'd2, lk: 1'b1, bc: 0};
        tbl[4] = '{n: 49,  st: 2'd2, lk: 1'b1, bc: 1};
        tbl[5] = '{n: 64,  st: 2'd2, lk: 1'b1, bc: 16};
        tbl[6] = '{n: 100, st: 2'd2, lk: 1'b1, bc: 52};

        reset_n    = 1'b0;
        data_in    = 1'b0;
        data_valid = 1'b0;
        clear_cnt  = 1'b0;
        g          = 16'h1001;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", sync_state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_bit_count", bit_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Clean stream: acquisition and lock timing
        for (int k = 0; k < 7; k++) begin
            while (nbits < tbl[k].n) step(1'b0, 1'b0);
            chk($sformatf("clean_state_%0d", tbl[k].n), sync_state, tbl[k].st);
            chk($sformatf("clean_locked_%0d", tbl[k].n), locked, tbl[k].lk);
            chk($sformatf("clean_bits_%0d", tbl[k].n), bit_count, tbl[k].bc);
            chk($sformatf("clean_errs_%0d", tbl[k].n), err_count, 0);
        end
        chk("clean_pulses", pulse_cnt, 0);

        // Sparse single-bit errors while locked
        for (int i = 0; i < 1000; i++) step((i % 100) == 50, 1'b0);
        chk("sparse_err_count", err_count, 10);
        chk("sparse_pulses", pulse_cnt, 10);
        chk("sparse_locked", locked, 1);
        chk("sparse_bit_count", bit_count, 1052);

        // clear_cnt coincident with an error
        step(1'b1, 1'b1);
        chk("clr_pulse", err_pulse, 1);
        chk("clr_err_count", err_count, 0);
        chk("clr_bit_count", bit_count, 0);
        step(1'b0, 1'b0);
        chk("clr_after_bits", bit_count, 1);
        chk("clr_after_errs", err_count, 0);

        // Asynchronous reset while locked
        step(1'b1, 1'b0);
        chk("pre_rst_pulse", err_pulse, 1);
        chk("pre_rst_err", err_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_state", sync_state, 0);
        chk("arst_pulse", err_pulse, 0);
        chk("arst_err", err_count, 0);
        chk("arst_bits", bit_count, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        g         = 16'h1001;
        nbits     = 0;
        pulse_cnt = 0;

        // Error burst forces loss of lock, then re-lock
        repeat (48) step(1'b0, 1'b0);
        chk("burst_prelock", locked, 1);
        repeat (10) step(1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b0);
        chk("burst_7_locked", locked, 1);
        step(1'b1, 1'b0);
        chk("burst_8_locked", locked, 0);
        chk("burst_8_state", sync_state, 0);
        chk("burst_err_count", err_count, 8);
        chk("burst_pulses", pulse_cnt, 8);
        repeat (47) step(1'b0, 1'b0);
        chk("relock_47", locked, 0);
        step(1'b0, 1'b0);
        chk("relock_48", locked, 1);
        chk("relock_err_count", err_count, 8);
        chk("relock_bit_count", bit_count, 18);

        // Error during VERIFY sends the FSM back to ACQUIRE
        hard_reset();
        repeat (20) step(1'b0, 1'b0);
        chk("verify_state_20", sync_state, 1);
        step(1'b1, 1'b0);
        chk("verify_err_state", sync_state, 0);
        while (nbits < 68) step(1'b0, 1'b0);
        chk("verify_locked_68", locked, 0);
        step(1'b0, 1'b0);
        chk("verify_locked_69", locked, 1);
        chk("verify_err_count", err_count, 0);
        chk("verify_pulses", pulse_cnt, 0);

        // All-zero input never leaves ACQUIRE
        hard_reset();
        left = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step_raw(1'b0, 1'b0);
            if (sync_state != 2'd0) left = 1'b1;
        end
        chk("zero_left_acquire", left, 0);
        chk("zero_locked", locked, 0);

        // Random valid gaps are transparent
        hard_reset();
        for (int v = 1; v <= 100; v++) begin
            repeat ($urandom_range(0, 2)) idle();
            step(1'b0, 1'b0);
            if (v == 16) chk("gap_state_16", sync_state, 1);
            if (v == 47) chk("gap_locked_47", locked, 0);
            if (v == 48) chk("gap_locked_48", locked, 1);
        end
        chk("gap_bit_count", bit_count, 52);
        chk("gap_err_count", err_count, 0);
        chk("gap_pulses", pulse_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
